alu_result_serializer: RTL and testbench

ALU_RESULT_SERIALIZER -- requirements
Module: alu_result_serializer

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_rec_fifo.sv | 58 +++++
 rtl/alu_result_serializer.sv | 109 ++++++++++
 tb/tb_alu_result_serializer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result serializer slice: opcode constants,
// the queued record layout, the serializer state encoding and the helpers
// that derive the per-packet header byte.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b1001;
  localparam logic [3:0] OP_SUB = 4'b1010;
  localparam logic [3:0] OP_MUL = 4'b1011;

  typedef struct packed {
    logic [3:0]  op;
    logic [7:0]  result;
    logic [15:0] product;
    logic        of;
    logic        zero;
    logic        slt;
  } alu_rec_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_D0   = 2'd2,
    ST_D1   = 2'd3
  } ser_state_t;

  function automatic logic rec_is_mul(input alu_rec_t r);
    return r.op == OP_MUL;
  endfunction

  // Header byte: {op, of, zero, slt, is_mul}
  function automatic logic [7:0] rec_hdr(input alu_rec_t r);
    return {r.op, r.of, r.zero, r.slt, rec_is_mul(r)};
  endfunction

endpackage

// File: rtl/alu_rec_fifo.sv
// DEPTH-entry record FIFO with asynchronous active-high reset.
// Ports:
//   clk, rst  - clock, async reset (clears pointers and occupancy)
//   i_push    - write i_rec at the tail (ignored when full)
//   i_rec     - record to write
//   i_pop     - drop the head record (ignored when empty)
//   o_head    - current head record (valid when o_count != 0)
//   o_count   - number of stored records
module alu_rec_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  alu_rec_t      i_rec,
  input  logic          i_pop,
  output alu_rec_t      o_head,
  output logic [AW:0]   o_count
);

  alu_rec_t          r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_push;
  logic              w_pop;

  assign w_push = i_push && (r_count != (AW+1)'(DEPTH));
  assign w_pop  = i_pop  && (r_count != '0);

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_rec;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/alu_result_serializer.sv
// Queues ALU result records and emits each as a byte packet:
//   header {op, of, zero, slt, is_mul}, then result (non-multiply) or
//   product[7:0], product[15:8] (multiply). out_last marks the final byte.
// Ports:
//   clk, rst                     - clock, async active-high reset
//   in_valid/in_ready            - record handshake
//   in_op/in_result/in_product   - record payload
//   in_of/in_zero/in_slt         - record flags
//   out_valid/out_ready          - byte stream handshake
//   out_data/out_last            - stream byte and end-of-packet marker
//   count                        - records held, including the one in flight
module alu_result_serializer
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_op,
  input  logic [7:0]               in_result,
  input  logic [15:0]              in_product,
  input  logic                     in_of,
  input  logic                     in_zero,
  input  logic                     in_slt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_data,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  ser_state_t  r_state;
  ser_state_t  w_state_nxt;
  alu_rec_t    w_rec;
  alu_rec_t    w_head;
  logic        w_push;
  logic        w_pop;
  logic        w_hs;
  logic        w_more;
  logic        w_mul;

  assign w_rec = '{op: in_op, result: in_result, product: in_product,
                   of: in_of, zero: in_zero, slt: in_slt};

  // Readiness comes from the registered count only, so a full FIFO refuses
  // a push even in the cycle its head is popped.
  assign in_ready = !rst && (count < CW'(DEPTH));
  assign w_push   = in_valid && in_ready;

  alu_rec_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_rec   (w_rec),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (count)
  );

  assign w_mul     = rec_is_mul(w_head);
  assign out_valid = (r_state != ST_IDLE);
  assign w_hs      = out_valid && out_ready;
  assign w_pop     = w_hs && (((r_state == ST_D0) && !w_mul) || (r_state == ST_D1));
  // After the pop, another record is available if more than one was held
  // or one arrives on this very edge.
  assign w_more    = (count > CW'(1)) || w_push;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_push || (count != '0)) w_state_nxt = ST_HDR;
      ST_HDR:  if (w_hs) w_state_nxt = ST_D0;
      ST_D0:   if (w_hs) w_state_nxt = w_mul ? ST_D1 : (w_more ? ST_HDR : ST_IDLE);
      ST_D1:   if (w_hs) w_state_nxt = w_more ? ST_HDR : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Byte mux depends only on state and head record, both frozen while stalled.
  always_comb begin
    out_data = '0;
    out_last = 1'b0;
    case (r_state)
      ST_HDR: out_data = rec_hdr(w_head);
      ST_D0: begin
        out_data = w_mul ? w_head.product[7:0] : w_head.result;
        out_last = !w_mul;
      end
      ST_D1: begin
        out_data = w_head.product[15:8];
        out_last = 1'b1;
      end
      default: begin
        out_data = '0;
        out_last = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_result_serializer.sv
module tb_alu_result_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [7:0]  in_result;
  logic [15:0] in_product;
  logic        in_of, in_zero, in_slt;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic [2:0]  count;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  logic [8:0]  exp_q [$];

  alu_result_serializer #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_result  (in_result),
    .in_product (in_product),
    .in_of      (in_of),
    .in_zero    (in_zero),
    .in_slt     (in_slt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_rec(input logic [3:0] op, input logic [7:0] res, input logic [15:0] prod,
                         input logic of, input logic z, input logic s);
    in_op = op; in_result = res; in_product = prod;
    in_of = of; in_zero = z; in_slt = s;
  endtask

  // Called at a negedge with out_ready=1; checks every presented byte against
  // exp_q, drops in_valid once a pending record is accepted, then expects idle.
  task automatic drain(input string tag);
    logic acc;
    int unsigned cyc = 0;
    while ((exp_q.size() != 0) && (cyc < 200)) begin
      acc = in_valid && in_ready;
      if (out_valid) chk({tag, "_byte"}, {23'd0, out_last, out_data}, {23'd0, exp_q.pop_front()});
      @(posedge clk);
      #1 if (acc) in_valid = 1'b0;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_left"}, exp_q.size(), 0);
    chk({tag, "_idle"}, {31'd0, out_valid}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    set_rec(4'h0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_ready", {31'd0, in_ready}, 0);
    chk("rst_count", {29'd0, count}, 0);
    chk("rst_data",  {23'd0, out_last, out_data}, 0);
    rst = 1'b0;
    #1 chk("ready_after_rst", {31'd0, in_ready}, 1);
    @(negedge clk);

    // Single add
    in_valid = 1'b1; set_rec(4'b1001, 8'h2A, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("add_pre_valid", {31'd0, out_valid}, 0);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("add_valid_rise", {31'd0, out_valid}, 1);
    chk("add_count", {29'd0, count}, 1);
    exp_q = '{9'h090, 9'h12A};
    drain("add");
    chk("add_count_end", {29'd0, count}, 0);

    // Multiply
    in_valid = 1'b1; set_rec(4'b1011, 8'h00, 16'hFF88, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    exp_q = '{9'h0B1, 9'h088, 9'h1FF};
    drain("mul");

    // Sub with slt
    in_valid = 1'b1; set_rec(4'b1010, 8'hFE, 16'h0000, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    exp_q = '{9'h0A2, 9'h1FE};
    drain("sub");

    // Pass-through opcode: product must be ignored
    in_valid = 1'b1; set_rec(4'b1100, 8'h5A, 16'h1234, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    exp_q = '{9'h0C8, 9'h15A};
    drain("pass");

    // Backpressure: five records, four fit
    out_ready = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      case (k)
        0: set_rec(4'b1001, 8'h11, 16'h0000, 1'b0, 1'b0, 1'b0);
        1: set_rec(4'b1011, 8'h00, 16'h1234, 1'b1, 1'b0, 1'b0);
        2: set_rec(4'b1010, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0);
        default: set_rec(4'b1111, 8'h77, 16'h0000, 1'b0, 1'b0, 1'b1);
      endcase
      @(posedge clk);
      @(negedge clk);
    end
    set_rec(4'b0001, 8'h3C, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("bp_ready_full", {31'd0, in_ready}, 0);
    chk("bp_count_full", {29'd0, count}, 4);
    for (int unsigned k = 0; k < 3; k++) begin
      chk("bp_stall_data", {23'd0, out_valid, out_data}, 9'h190);
      @(negedge clk);
    end
    chk("bp_stall_count", {29'd0, count}, 4);
    out_ready = 1'b1;
    exp_q = '{9'h090, 9'h111, 9'h0B9, 9'h034, 9'h112, 9'h0A4, 9'h100,
              9'h0F2, 9'h177, 9'h010, 9'h13C};
    drain("bp");

    // Full with pop on the same edge: push refused, then accepted
    out_ready = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      set_rec(4'b1001, 8'hA0 + 8'(k), 16'h0000, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
    end
    set_rec(4'b1001, 8'hA4, 16'h0000, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    chk("fp_ready0", {31'd0, in_ready}, 0);
    @(negedge clk);
    chk("fp_last_byte", {23'd0, out_last, out_data}, 9'h1A0);
    chk("fp_count4", {29'd0, count}, 4);
    chk("fp_refused", {31'd0, in_ready}, 0);
    @(negedge clk);
    chk("fp_count3", {29'd0, count}, 3);
    chk("fp_ready1", {31'd0, in_ready}, 1);
    @(negedge clk);
    chk("fp_count_back4", {29'd0, count}, 4);
    in_valid = 1'b0;
    exp_q = '{9'h1A1, 9'h090, 9'h1A2, 9'h090, 9'h1A3, 9'h090, 9'h1A4};
    drain("fp");

    // Reset during D0 of a multiply with a second record queued
    in_valid = 1'b1; set_rec(4'b1011, 8'h00, 16'hABCD, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    set_rec(4'b1001, 8'h55, 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("rm_d0_data", {23'd0, out_valid, out_data}, 9'h1CD);
    chk("rm_count2", {29'd0, count}, 2);
    rst = 1'b1;
    #1;
    chk("rm_valid0", {31'd0, out_valid}, 0);
    chk("rm_count0", {29'd0, count}, 0);
    chk("rm_data0", {23'd0, out_last, out_data}, 0);
    chk("rm_ready0", {31'd0, in_ready}, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int unsigned k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rm_quiet", {31'd0, out_valid}, 0);
    end
    in_valid = 1'b1; set_rec(4'b1001, 8'h42, 16'h0000, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    exp_q = '{9'h094, 9'h142};
    drain("rm_new");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
